// File: rtl/key_decoder_binary_pkg.sv
// Shared definitions for the keypad decode path.
// - cmd_class_t : command class presented to the calculator core
// - KC_*        : code-byte constants for operator and control keys
// - state_t     : handshake FSM states
// - cmd_t       : decoded command (class + argument)
// - decode_key(): maps a code byte onto a cmd_t
package key_pkg;

    typedef enum logic [2:0] {
        DIGIT   = 3'd0,
        OP      = 3'd1,
        ENTER   = 3'd2,
        CLEAR   = 3'd3,
        BACK    = 3'd4,
        INVALID = 3'd7
    } cmd_class_t;

    localparam logic [7:0] KC_ADD       = 8'h10;
    localparam logic [7:0] KC_SUB       = 8'h11;
    localparam logic [7:0] KC_MUL       = 8'h12;
    localparam logic [7:0] KC_DET       = 8'h13;
    localparam logic [7:0] KC_TRANSPOSE = 8'h14;
    localparam logic [7:0] KC_ENTER     = 8'h20;
    localparam logic [7:0] KC_CLEAR     = 8'h21;
    localparam logic [7:0] KC_BACK      = 8'h22;

    typedef enum logic {
        IDLE = 1'b0,
        HOLD = 1'b1
    } state_t;

    typedef struct packed {
        cmd_class_t cls;
        logic [3:0] arg;
    } cmd_t;

    function automatic cmd_t decode_key(input logic [7:0] b);
        cmd_t c;
        c.cls = INVALID;
        c.arg = 4'h0;
        if (b[7:4] == 4'h0) begin
            c.cls = DIGIT;
            c.arg = b[3:0];
        end else begin
            case (b)
                KC_ADD, KC_SUB, KC_MUL, KC_DET, KC_TRANSPOSE: begin
                    // Operator index is the low nibble: ADD=0 ... TRANSPOSE=4.
                    c.cls = OP;
                    c.arg = b[3:0];
                end
                KC_ENTER: c.cls = ENTER;
                KC_CLEAR: c.cls = CLEAR;
                KC_BACK:  c.cls = BACK;
                default:  c.cls = INVALID;
            endcase
        end
        return c;
    endfunction

endpackage

// File: rtl/key_decoder_binary_if.sv
// Command handshake between the key decoder and the calculator control FSM.
// - out_valid : held command is valid            (master -> slave)
// - out_ready : consumer accepts it this cycle   (slave -> master)
// - cmd_class : command class                    (master -> slave)
// - cmd_arg   : digit value or operator index    (master -> slave)
interface key_decoder_binary_if;
    import key_pkg::*;

    logic       out_valid;
    logic       out_ready;
    cmd_class_t cmd_class;
    logic [3:0] cmd_arg;

    modport master (
        output out_valid,
        output cmd_class,
        output cmd_arg,
        input  out_ready
    );

    modport slave (
        input  out_valid,
        input  cmd_class,
        input  cmd_arg,
        output out_ready
    );

endinterface

// File: rtl/key_decoder_binary_hex_to_ssd.sv
// Hex nibble to seven-segment pattern, combinational.
// - nibble_i : 4-bit value 0..F
// - seg_o    : active-high segments {dp, g, f, e, d, c, b, a}; dp always off
module hex_to_ssd (
    input  logic [3:0] nibble_i,
    output logic [7:0] seg_o
);

    always_comb begin
        case (nibble_i)
            4'h0: seg_o = 8'h3F;
            4'h1: seg_o = 8'h06;
            4'h2: seg_o = 8'h5B;
            4'h3: seg_o = 8'h4F;
            4'h4: seg_o = 8'h66;
            4'h5: seg_o = 8'h6D;
            4'h6: seg_o = 8'h7D;
            4'h7: seg_o = 8'h07;
            4'h8: seg_o = 8'h7F;
            4'h9: seg_o = 8'h6F;
            4'hA: seg_o = 8'h77;
            4'hB: seg_o = 8'h7C;
            4'hC: seg_o = 8'h39;
            4'hD: seg_o = 8'h5E;
            4'hE: seg_o = 8'h79;
            default: seg_o = 8'h71;
        endcase
    end

endmodule

// File: rtl/key_decoder_binary.sv
// Keypad receive path: detects each newly completed keycode, decodes it into
// a calculator command and holds it under a valid/ready handshake.
// - clk, reset : system clock, asynchronous active-high reset
// - keycode    : [8] code-complete level, [7:0] code byte
// - clear_err  : synchronous clear of overflow and err_count
// - cmd_bus    : out_valid/out_ready/cmd_class/cmd_arg handshake (master side)
// - overflow   : sticky, a code arrived while a command was still held
// - err_count  : saturating count of INVALID commands captured
// - ss1, ss0   : seven-segment echo of the last code byte (high, low nibble)
module key_decoder_binary
    import key_pkg::*;
#(
    parameter int ERR_W = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [8:0]           keycode,
    input  logic                 clear_err,
    key_decoder_binary_if.master cmd_bus,
    output logic                 overflow,
    output logic [ERR_W-1:0]     err_count,
    output logic [7:0]           ss1,
    output logic [7:0]           ss0
);

    state_t           state_q, state_d;
    logic             prev_q;
    cmd_t             cmd_q, cmd_d;
    logic             overflow_q, overflow_d;
    logic [ERR_W-1:0] err_q, err_d;
    logic [7:0]       ss1_q, ss1_d, ss0_q, ss0_d;

    logic             new_code;
    logic             cmd_load;
    cmd_t             decoded;
    logic [7:0]       seg_hi, seg_lo;

    // Rising edge of the code-complete level; a level held high counts once.
    assign new_code = keycode[8] & ~prev_q;
    assign decoded  = decode_key(keycode[7:0]);

    hex_to_ssd u_ssd_hi (.nibble_i(keycode[7:4]), .seg_o(seg_hi));
    hex_to_ssd u_ssd_lo (.nibble_i(keycode[3:0]), .seg_o(seg_lo));

    always_comb begin
        // NOTE: every variable gets its hold value first so no path leaves it unassigned (no latches).
        state_d    = state_q;
        cmd_d      = cmd_q;
        overflow_d = overflow_q;
        err_d      = err_q;
        ss1_d      = ss1_q;
        ss0_d      = ss0_q;
        cmd_load   = 1'b0;

        case (state_q)
            IDLE: begin
                if (new_code) begin
                    cmd_load = 1'b1;
                    state_d  = HOLD;
                end
            end
            HOLD: begin
                if (cmd_bus.out_ready) begin
                    // A code arriving in the transfer cycle replaces the one leaving.
                    if (new_code) cmd_load = 1'b1;
                    else          state_d  = IDLE;
                end else if (new_code) begin
                    overflow_d = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase

        // The echo follows every new code, including ones dropped on overflow.
        if (new_code) begin
            ss1_d = seg_hi;
            ss0_d = seg_lo;
        end

        // Only codes actually presented to the core are counted; drops show up as overflow.
        if (cmd_load) begin
            cmd_d = decoded;
            if (decoded.cls == INVALID && err_q != {ERR_W{1'b1}})
                err_d = err_q + ERR_W'(1);
        end

        if (clear_err) begin
            overflow_d = 1'b0;
            err_d      = '0;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            prev_q     <= 1'b0;
            cmd_q      <= '{cls: DIGIT, arg: 4'h0};
            overflow_q <= 1'b0;
            err_q      <= '0;
            ss1_q      <= 8'h00;
            ss0_q      <= 8'h00;
        end else begin
            state_q    <= state_d;
            prev_q     <= keycode[8];
            cmd_q      <= cmd_d;
            overflow_q <= overflow_d;
            err_q      <= err_d;
            ss1_q      <= ss1_d;
            ss0_q      <= ss0_d;
        end
    end

    assign cmd_bus.out_valid = (state_q == HOLD);
    assign cmd_bus.cmd_class = cmd_q.cls;
    assign cmd_bus.cmd_arg   = cmd_q.arg;
    assign overflow          = overflow_q;
    assign err_count         = err_q;
    assign ss1               = ss1_q;
    assign ss0               = ss0_q;

endmodule
